jtdd2_shared_arb: RTL and testbench

JTDD2_SHARED_ARB -- requirements
Module: jtdd2_shared_arb

---
 rtl/jtdd2_pkg.sv | 16 +
 rtl/jtdd2_shared_arb_if.sv | 29 ++
 rtl/jtdd2_rr_pick.sv | 25 ++
 rtl/jtdd2_shared_arb.sv | 102 ++++++++++
 tb/tb_jtdd2_shared_arb.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jtdd2_pkg.sv
// Shared types for the main/sub Z80 shared-RAM arbiter.
package jtdd2_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_MAIN = 1'b0,
    OWN_SUB  = 1'b1
  } owner_t;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 8;
endpackage

// File: rtl/jtdd2_shared_arb_if.sv
// CPU-side and RAM-side bus of the shared-RAM arbiter.
interface jtdd2_shared_arb_if #(
  parameter int AW = jtdd2_pkg::AW_DEF,
  parameter int DW = jtdd2_pkg::DW_DEF
);
  logic          main_cs, main_wrn, main_ok, main_lock, lock_ack;
  logic [AW-1:0] main_addr;
  logic [DW-1:0] main_din, main_dout;
  logic          sub_cs, sub_wrn, sub_ok;
  logic [AW-1:0] sub_addr;
  logic [DW-1:0] sub_din, sub_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_q;
  logic          ram_we;

  modport slave (
    input  main_cs, main_wrn, main_addr, main_din, main_lock,
    input  sub_cs, sub_wrn, sub_addr, sub_din, ram_q,
    output main_dout, main_ok, lock_ack, sub_dout, sub_ok,
    output ram_addr, ram_din, ram_we
  );

  modport master (
    output main_cs, main_wrn, main_addr, main_din, main_lock,
    output sub_cs, sub_wrn, sub_addr, sub_din, ram_q,
    input  main_dout, main_ok, lock_ack, sub_dout, sub_ok,
    input  ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/jtdd2_rr_pick.sv
// Two-input round-robin picker; a tie goes to the side not granted last.
module jtdd2_rr_pick import jtdd2_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic req_main,
  input  logic req_sub,
  input  logic en,
  output logic gnt_main,
  output logic gnt_sub
);
  owner_t last_q, last_d;

  always_comb begin
    gnt_main = req_main & (~req_sub | (last_q == OWN_SUB));
    gnt_sub  = req_sub  & (~req_main | (last_q == OWN_MAIN));
    last_d   = last_q;
    if (en && gnt_main)     last_d = OWN_MAIN;
    else if (en && gnt_sub) last_d = OWN_SUB;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= OWN_SUB;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/jtdd2_shared_arb.sv
// Main/sub CPU arbiter for one single-port shared RAM: IDLE -> ACCESS -> DONE,
// round-robin on ties, and a main-side lock that holds the sub CPU off.
module jtdd2_shared_arb import jtdd2_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic                clk,
  input logic                rst,
  jtdd2_shared_arb_if.slave  bus
);
  arb_state_t    st_q, st_d;
  owner_t        own_q, own_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] mdout_q, mdout_d, sdout_q, sdout_d;
  logic          we_q, we_d, ack_q, ack_d;
  logic          sub_elig, gnt_main, gnt_sub, rd_done;

  assign sub_elig = bus.sub_cs & ~bus.main_lock;

  jtdd2_rr_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .req_main (bus.main_cs),
    .req_sub  (sub_elig),
    .en       (st_q == ST_IDLE),
    .gnt_main (gnt_main),
    .gnt_sub  (gnt_sub)
  );

  always_comb begin
    st_d    = st_q;
    own_d   = own_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    mdout_d = mdout_q;
    sdout_d = sdout_q;
    case (st_q)
      ST_IDLE: begin
        if (gnt_main) begin
          st_d   = ST_ACCESS;
          own_d  = OWN_MAIN;
          addr_d = bus.main_addr;
          din_d  = bus.main_din;
          we_d   = ~bus.main_wrn;
        end else if (gnt_sub) begin
          st_d   = ST_ACCESS;
          own_d  = OWN_SUB;
          addr_d = bus.sub_addr;
          din_d  = bus.sub_din;
          we_d   = ~bus.sub_wrn;
        end
      end
      ST_ACCESS: st_d = ST_DONE;
      ST_DONE: begin
        st_d = ST_IDLE;
        if (!we_q) begin
          if (own_q == OWN_MAIN) mdout_d = bus.ram_q;
          else                   sdout_d = bus.ram_q;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    // Lock is granted only when no sub cycle can still be in flight.
    ack_d = bus.main_lock & (ack_q | (st_q == ST_IDLE) |
                             ((st_q == ST_DONE) & (own_q == OWN_MAIN)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      own_q   <= OWN_MAIN;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      mdout_q <= '0;
      sdout_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      mdout_q <= mdout_d;
      sdout_q <= sdout_d;
      ack_q   <= ack_d;
    end
  end

  // Read data is forwarded straight from the RAM during DONE so it is valid with ok.
  assign rd_done       = (st_q == ST_DONE) & ~we_q;
  assign bus.main_ok   = (st_q == ST_DONE) & (own_q == OWN_MAIN);
  assign bus.sub_ok    = (st_q == ST_DONE) & (own_q == OWN_SUB);
  assign bus.main_dout = (rd_done && own_q == OWN_MAIN) ? bus.ram_q : mdout_q;
  assign bus.sub_dout  = (rd_done && own_q == OWN_SUB)  ? bus.ram_q : sdout_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;
  assign bus.ram_we    = (st_q == ST_ACCESS) & we_q & ~rst;
  assign bus.lock_ack  = ack_q;
endmodule

// File: tb/tb_jtdd2_shared_arb.sv
// Bench for jtdd2_shared_arb: directed table, reset/lock sequences, random traffic.
module tb_jtdd2_shared_arb;
  import jtdd2_pkg::*;
  localparam int AW = 9;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  jtdd2_shared_arb_if #(.AW(AW), .DW(DW)) bus();
  jtdd2_shared_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 'h5A);
  endfunction

  // Single-port RAM with one cycle of registered read latency.
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 512; i++) mem[i] <= pat(i);
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_q <= mem[bus.ram_addr];
  end

  logic [7:0] ref_mem [512];
  logic [7:0] exp_dout [2];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit cs, input bit wr,
                       input logic [8:0] a, input logic [7:0] d);
    if (p == 0) begin
      bus.main_cs = cs; bus.main_wrn = ~wr; bus.main_addr = a; bus.main_din = d;
    end else begin
      bus.sub_cs = cs; bus.sub_wrn = ~wr; bus.sub_addr = a; bus.sub_din = d;
    end
  endtask

  function automatic logic ok_of(input int p);
    return (p == 0) ? bus.main_ok : bus.sub_ok;
  endfunction

  function automatic logic [7:0] dout_of(input int p);
    return (p == 0) ? bus.main_dout : bus.sub_dout;
  endfunction

  // Reference: accesses are serialised, so they take effect in ok order.
  task automatic model_ok(input int p, input bit wr, input logic [8:0] a, input logic [7:0] d);
    if (wr) begin
      chk("dout_hold_on_write", int'(dout_of(p)), int'(exp_dout[p]));
      ref_mem[a] = d;
    end else begin
      chk("read_data", int'(dout_of(p)), int'(ref_mem[a]));
      exp_dout[p] = ref_mem[a];
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_main_ok"}, int'(bus.main_ok), 0);
    chk({tag, "_sub_ok"}, int'(bus.sub_ok), 0);
    chk({tag, "_ram_we"}, int'(bus.ram_we), 0);
    chk({tag, "_lock_ack"}, int'(bus.lock_ack), 0);
    chk({tag, "_main_dout"}, int'(bus.main_dout), 0);
    chk({tag, "_sub_dout"}, int'(bus.sub_dout), 0);
    chk({tag, "_ram_addr"}, int'(bus.ram_addr), 0);
    chk({tag, "_ram_din"}, int'(bus.ram_din), 0);
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;
  endtask

  // One uncontested access; lat counts edges from cs sample to the ok cycle.
  task automatic access(input int p, input bit wr, input logic [8:0] a,
                        input logic [7:0] d, output int lat);
    drive(p, 1'b1, wr, a, d);
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        chk("acc_ram_addr", int'(bus.ram_addr), int'(a));
        chk("acc_ram_we", int'(bus.ram_we), int'(wr));
        if (wr) chk("acc_ram_din", int'(bus.ram_din), int'(d));
      end
    end while (!ok_of(p) && lat < 10);
    drive(p, 1'b0, 1'b0, a, d);
    chk("acc_ok_seen", int'(ok_of(p)), 1);
    if (ok_of(p)) model_ok(p, wr, a, d);
  endtask

  task automatic traffic(input int nacc, input int pct, input bit alt);
    bit busy[2], jd[2], wr[2];
    logic [8:0] a[2];
    logic [7:0] d[2];
    int wt[2];
    int issued = 0, done = 0, guard = 0, last = 1;
    logic prev_we = 1'b0;
    for (int p = 0; p < 2; p++) begin
      busy[p] = 0; jd[p] = 0; wr[p] = 0; a[p] = '0; d[p] = '0; wt[p] = 0;
    end
    bus.main_lock = 1'b0;
    while (done < nacc && guard < 5000) begin
      for (int p = 0; p < 2; p++) begin
        if (!busy[p] && !jd[p] && issued < nacc && $urandom_range(99) < pct) begin
          busy[p] = 1'b1;
          wr[p]   = 1'($urandom_range(1));
          a[p]    = ($urandom_range(3) == 0) ? 9'($urandom_range(511))
                                             : 9'($urandom_range(8) + 'h1F7);
          d[p]    = 8'($urandom);
          wt[p]   = 0;
          issued++;
        end
        drive(p, busy[p], wr[p], a[p], d[p]);
      end
      tick();
      guard++;
      chk("ram_we_back_to_back", int'(prev_we & bus.ram_we), 0);
      prev_we = bus.ram_we;
      for (int p = 0; p < 2; p++) begin
        jd[p] = 1'b0;
        chk("ok_without_request", int'(ok_of(p) & ~busy[p]), 0);
        if (busy[p]) begin
          wt[p]++;
          if (ok_of(p)) begin
            chk("ok_wait_le5", int'(wt[p] <= 5), 1);
            model_ok(p, wr[p], a[p], d[p]);
            if (alt) chk("rr_alternate", p, 1 - last);
            last = p;
            busy[p] = 1'b0;
            jd[p] = 1'b1;
            done++;
          end
        end
      end
    end
    chk("traffic_completed", done, nacc);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
  endtask

  typedef struct {
    int         p;
    bit         wr;
    logic [8:0] a;
    logic [7:0] d;
    logic [7:0] exp_q;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int lat, n, nbad;

    tbl[0] = '{1, 1'b1, 9'h1A5, 8'h3C, 8'h00};
    tbl[1] = '{0, 1'b0, 9'h1A5, 8'h00, 8'h3C};
    tbl[2] = '{0, 1'b1, 9'h1FF, 8'hE7, 8'h3C};
    tbl[3] = '{0, 1'b0, 9'h1FF, 8'h00, 8'hE7};
    tbl[4] = '{1, 1'b0, 9'h000, 8'h00, 8'h5A};
    tbl[5] = '{1, 1'b1, 9'h010, 8'hAA, 8'h5A};
    tbl[6] = '{1, 1'b0, 9'h010, 8'h00, 8'hAA};

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    bus.main_lock = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);

    rst = 1'b1; mem_init = 1'b1;
    tick(); tick();
    chk_reset("por");
    rst = 1'b0; mem_init = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      access(tbl[i].p, tbl[i].wr, tbl[i].a, tbl[i].d, lat);
      chk("tbl_latency", lat, 2);
      chk("tbl_dout", int'(dout_of(tbl[i].p)), int'(tbl[i].exp_q));
      tick();
    end

    // Reset landing on the ACCESS cycle of a sub write must drop the write.
    drive(1, 1'b1, 1'b1, 9'h010, 8'h55);
    tick();
    drive(1, 1'b0, 1'b0, 9'h010, 8'h55);
    chk("abort_in_access", int'(bus.ram_addr), 'h010);
    rst = 1'b1;
    #1;
    chk("abort_we_suppressed", int'(bus.ram_we), 0);
    tick();
    rst = 1'b0;
    chk_reset("abort");
    tick();
    chk("abort_no_late_ok", int'(bus.sub_ok), 0);
    access(1, 1'b0, 9'h010, 8'h00, lat);
    chk("abort_prior_value", int'(bus.sub_dout), 'hAA);
    tick();

    traffic(8, 100, 1'b1);

    // Lock raised while a sub access is in ACCESS.
    drive(1, 1'b1, 1'b0, 9'h1A5, 8'h00);
    tick();
    chk("lock_sub_in_access", int'(bus.ram_addr), 'h1A5);
    drive(1, 1'b0, 1'b0, 9'h1A5, 8'h00);
    bus.main_lock = 1'b1;
    tick();
    chk("lock_sub_ok", int'(bus.sub_ok), 1);
    chk("lock_ack_not_yet", int'(bus.lock_ack), 0);
    if (bus.sub_ok) model_ok(1, 1'b0, 9'h1A5, 8'h00);
    n = 0;
    while (!bus.lock_ack && n < 4) begin tick(); n++; end
    chk("lock_ack_rise", int'(bus.lock_ack), 1);
    drive(1, 1'b1, 1'b1, 9'h020, 8'h99);
    nbad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nbad += int'(bus.sub_ok | bus.ram_we);
    end
    chk("lock_sub_stalled", nbad, 0);
    access(0, 1'b0, 9'h1A5, 8'h00, lat);
    chk("lock_main_latency", lat, 2);
    chk("lock_ack_held", int'(bus.lock_ack), 1);
    tick();
    bus.main_lock = 1'b0;
    tick();
    chk("lock_ack_fall", int'(bus.lock_ack), 0);
    n = 0;
    while (!bus.sub_ok && n < 6) begin tick(); n++; end
    chk("lock_sub_resumes", int'(bus.sub_ok), 1);
    if (bus.sub_ok) model_ok(1, 1'b1, 9'h020, 8'h99);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();

    traffic(200, 35, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
